// File: rtl/lego_weight_load_seq.sv
// Weight-load / compute / drain sequencer for one systolic-array tile.
// Optional macro LEGO_SEQ_STALL_CNT_EN adds a saturating compute-stall counter.
module lego_weight_load_seq #(
    parameter int N_ROWS    = 16,
    parameter int ROW_W     = 128,
    parameter int N_COMPUTE = 32,
    parameter int N_DRAIN   = 31
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      w_valid,
    input  logic [ROW_W-1:0]          w_data,
    output logic                      w_ready,
    output logic                      w_load_en,
    output logic [$clog2(N_ROWS)-1:0] w_row_sel,
    output logic [ROW_W-1:0]          w_row_data,
    input  logic                      act_valid,
    output logic                      compute_en,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               stall_cycles
);

    localparam int SEL_W = $clog2(N_ROWS);
    localparam int CMP_W = $clog2(N_COMPUTE + 1);
    localparam int DRN_W = $clog2(N_DRAIN + 1);

    localparam logic [SEL_W-1:0] LAST_ROW  = SEL_W'(N_ROWS - 1);
    localparam logic [CMP_W-1:0] LAST_CMP  = CMP_W'(N_COMPUTE - 1);
    localparam logic [DRN_W-1:0] LAST_DRN  = DRN_W'(N_DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   row_cnt_q, row_cnt_d;
    logic [CMP_W-1:0]   cmp_cnt_q, cmp_cnt_d;
    logic [DRN_W-1:0]   drn_cnt_q, drn_cnt_d;
    logic               load_en_q;
    logic [SEL_W-1:0]   row_sel_q;
    logic [ROW_W-1:0]   row_data_q;
    logic               accept;
    logic               start_accept;

    assign accept       = w_valid && (state_q == S_LOAD);
    assign start_accept = start && (state_q == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_cnt_q  <= '0;
            cmp_cnt_q  <= '0;
            drn_cnt_q  <= '0;
            load_en_q  <= 1'b0;
            row_sel_q  <= '0;
            row_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            cmp_cnt_q <= cmp_cnt_d;
            drn_cnt_q <= drn_cnt_d;
            load_en_q <= accept;
            // Row index and data are captured together so the array sees a consistent write.
            if (accept) begin
                row_sel_q  <= row_cnt_q;
                row_data_q <= w_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        cmp_cnt_d  = cmp_cnt_q;
        drn_cnt_d  = drn_cnt_q;
        w_ready    = 1'b0;
        compute_en = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    row_cnt_d = '0;
                    cmp_cnt_d = '0;
                    drn_cnt_d = '0;
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    if (row_cnt_q == LAST_ROW) begin
                        state_d = S_COMPUTE;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                compute_en = act_valid;
                if (act_valid) begin
                    if (cmp_cnt_q == LAST_CMP) begin
                        state_d = S_DRAIN;
                    end else begin
                        cmp_cnt_d = cmp_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drn_cnt_q == LAST_DRN) begin
                    state_d = S_DONE;
                end else begin
                    drn_cnt_d = drn_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign w_load_en  = load_en_q;
    assign w_row_sel  = row_sel_q;
    assign w_row_data = row_data_q;

`ifdef LEGO_SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_accept) begin
            stall_q <= '0;
        end else if ((state_q == S_COMPUTE) && !act_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
    assign stall_cycles        = 16'd0;
`endif

endmodule

// File: tb/tb_lego_weight_load_seq.sv
// Scoreboard bench: driver pushes expected events with their cycle stamps, a monitor pops and compares.
module tb_lego_weight_load_seq;

    localparam int N_ROWS    = 16;
    localparam int ROW_W     = 128;
    localparam int N_COMPUTE = 32;
    localparam int N_DRAIN   = 31;
    localparam int SEL_W     = $clog2(N_ROWS);

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              w_valid;
    logic [ROW_W-1:0]  w_data;
    logic              w_ready;
    logic              w_load_en;
    logic [SEL_W-1:0]  w_row_sel;
    logic [ROW_W-1:0]  w_row_data;
    logic              act_valid;
    logic              compute_en;
    logic              busy;
    logic              done;
    logic [15:0]       stall_cycles;

    lego_weight_load_seq #(
        .N_ROWS(N_ROWS), .ROW_W(ROW_W), .N_COMPUTE(N_COMPUTE), .N_DRAIN(N_DRAIN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready), .w_load_en(w_load_en), .w_row_sel(w_row_sel),
        .w_row_data(w_row_data), .act_valid(act_valid), .compute_en(compute_en),
        .busy(busy), .done(done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        int               sel;
        logic [ROW_W-1:0] data;
    } load_t;

    typedef struct {
        int cyc;
        int stall;
    } done_t;

    load_t load_q[$];
    int    comp_q[$];
    done_t done_q[$];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int tiles_completed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ROW_W-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every observed output event must match the oldest expectation.
    always @(negedge clk) begin
        if (w_load_en === 1'b1) begin
            if (load_q.size() == 0) begin
                chk("load_unexpected", 1, 0);
            end else begin
                load_t e;
                e = load_q.pop_front();
                chk("load_cycle", cyc, e.cyc);
                chk("load_row_sel", w_row_sel, e.sel);
                chk("load_row_data", w_row_data, e.data);
                $display("load  cyc=%0d row=%0d data=%h", cyc, w_row_sel, w_row_data);
            end
        end
        if (compute_en === 1'b1) begin
            if (comp_q.size() == 0) begin
                chk("compute_unexpected", 1, 0);
            end else begin
                chk("compute_cycle", cyc, comp_q.pop_front());
            end
        end
        if (done === 1'b1) begin
            done_seen++;
            if (done_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("done_stall_cycles", stall_cycles, d.stall);
                $display("done  cyc=%0d stall_cycles=%0d", cyc, stall_cycles);
            end
        end
`ifndef LEGO_SEQ_STALL_CNT_EN
        if (cyc > 0) chk("stall_tied_zero", stall_cycles, 0);
`endif
    end

    // load_mode: 0 back-to-back, 1 alternating, 2 random gaps.
    // act_mode : 0 random, 1 always valid, 2 five-cycle gap after 10 steps.
    task automatic run_tile(input int load_mode, input int act_mode, input int abort_row);
        int n;
        int stalls;
        int gap;
        int idles;
        int exp_stall;
        done_t d;
        load_t e;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_in_load", busy, 1);
        for (int r = 0; r < N_ROWS; r++) begin
            if (load_mode == 0)      idles = 0;
            else if (load_mode == 1) idles = (r == 0) ? 0 : 1;
            else                     idles = $urandom_range(0, 3);
            repeat (idles) begin
                w_valid = 1'b0;
                w_data  = rand_row();
                start   = ($urandom_range(0, 3) == 0);
                tick();
            end
            w_valid = 1'b1;
            w_data  = rand_row();
            start   = ($urandom_range(0, 3) == 0);
            chk("w_ready_load", w_ready, 1);
            e.cyc  = cyc + 1;
            e.sel  = r;
            e.data = w_data;
            load_q.push_back(e);
            tick();
            if (r == abort_row) begin
                w_valid = 1'b0;
                start   = 1'b1;
                rst     = 1'b1;
                tick();
                rst   = 1'b0;
                start = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_w_ready", w_ready, 0);
                chk("abort_row_sel", w_row_sel, 0);
                chk("abort_load_en", w_load_en, 0);
                chk("abort_done", done, 0);
                return;
            end
        end
        w_valid = 1'b0;
        start   = 1'b0;
        chk("w_ready_compute", w_ready, 0);
        n = 0;
        stalls = 0;
        gap = 0;
        while (n < N_COMPUTE) begin
            if (act_mode == 0) begin
                act_valid = ($urandom_range(0, 2) != 0);
            end else if (act_mode == 2 && n == 10 && gap < 5) begin
                act_valid = 1'b0;
                gap++;
            end else begin
                act_valid = 1'b1;
            end
            start = ($urandom_range(0, 3) == 0);
            if (act_valid) begin
                comp_q.push_back(cyc);
                n++;
            end else begin
                stalls++;
            end
            tick();
        end
        start = 1'b0;
`ifdef LEGO_SEQ_STALL_CNT_EN
        exp_stall = (stalls > 65535) ? 65535 : stalls;
`else
        exp_stall = 0;
`endif
        d.cyc   = cyc + N_DRAIN;
        d.stall = exp_stall;
        done_q.push_back(d);
        repeat (N_DRAIN) begin
            act_valid = $urandom_range(0, 1) == 1;
            tick();
        end
        act_valid = 1'b0;
        start = 1'b1;
        chk("busy_in_done", busy, 1);
        tick();
        start = 1'b0;
        chk("idle_after_done", busy, 0);
        tiles_completed++;
        tick();
        chk("idle_start_ignored_in_done", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        w_valid   = 1'b0;
        w_data    = '0;
        act_valid = 1'b0;
        tick();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_w_ready", w_ready, 0);
        chk("reset_load_en", w_load_en, 0);
        chk("reset_row_sel", w_row_sel, 0);
        chk("reset_row_data", w_row_data, 0);
        chk("reset_compute_en", compute_en, 0);
        chk("reset_done", done, 0);
        chk("reset_stall", stall_cycles, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        run_tile(0, 1, -1);
        run_tile(1, 1, -1);
        run_tile(2, 2, -1);
        run_tile(2, 0, 7);
        repeat (3) tick();
        chk("after_abort_busy", busy, 0);
        run_tile(0, 2, -1);
        for (int t = 0; t < 4; t++) begin
            run_tile(2, 0, -1);
        end
        repeat (5) tick();

        chk("load_queue_empty", load_q.size(), 0);
        chk("compute_queue_empty", comp_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        chk("done_count", done_seen, tiles_completed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lego_weight_load_seq.md
LEGO_WEIGHT_LOAD_SEQ -- requirements
Module: lego_weight_load_seq

Interface
REQ-001 Parameter N_ROWS, default 16; weight rows loaded per tile, one row per accepted beat.
REQ-002 Parameter ROW_W, default 128; bits per weight row.
REQ-003 Parameter N_COMPUTE, default 32; active compute cycles per tile.
REQ-004 Parameter N_DRAIN, default 31; pipeline drain cycles after compute.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  single-cycle request to begin one tile.
REQ-008 w_valid  input  1  weight buffer presents a row.
REQ-009 w_data  input  ROW_W  weight row data.
REQ-010 w_ready  output  1  block accepts a row this cycle.
REQ-011 w_load_en  output  1  write strobe to the systolic-array weight registers.
REQ-012 w_row_sel  output  $clog2(N_ROWS)  target row index for w_load_en.
REQ-013 w_row_data  output  ROW_W  registered copy of the accepted w_data.
REQ-014 act_valid  input  1  activation stream available.
REQ-015 compute_en  output  1  array advances one compute step.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at tile completion.
REQ-018 stall_cycles  output  16  compute stall count (see Configuration).

Function
REQ-019 FSM states are IDLE, LOAD, COMPUTE, DRAIN and DONE; transitions occur only on rising clk.
REQ-020 IDLE -> LOAD when start=1; start SHALL be ignored in every other state.
REQ-021 In LOAD, w_ready=1; a beat is accepted when w_valid&w_ready; the row counter starts at 0 and increments by 1 per accepted beat.
REQ-022 An accepted beat SHALL produce w_load_en=1, w_row_sel=row counter at acceptance, and w_row_data=w_data exactly one cycle later (latency 1).
REQ-023 w_valid=0 in LOAD SHALL hold the row counter and produce no w_load_en; the number of idle cycles is unbounded.
REQ-024 On acceptance of row N_ROWS-1, w_ready SHALL drop in the next cycle and the FSM SHALL enter COMPUTE; the row counter never wraps inside a tile.
REQ-025 In COMPUTE, compute_en=act_valid; the compute counter increments only when compute_en=1.
REQ-026 COMPUTE -> DRAIN in the cycle after the N_COMPUTE-th compute_en.
REQ-027 DRAIN lasts exactly N_DRAIN cycles regardless of act_valid, with compute_en=0; then DONE.
REQ-028 DONE lasts one cycle with done=1, then returns to IDLE; a start in the DONE cycle is ignored.
REQ-029 w_ready, w_load_en, compute_en and done SHALL be 0 in every state not named for them above.

Reset
REQ-030 With rst=1 at a clock edge, the FSM SHALL enter IDLE, all counters SHALL clear to 0, and all outputs SHALL be 0 (w_row_data 0, stall_cycles 0) in the next cycle.
REQ-031 rst SHALL take priority over start and handshakes; a reset during LOAD/COMPUTE/DRAIN abandons the tile with no done pulse.

Configuration
REQ-032 Macro LEGO_SEQ_STALL_CNT_EN: when defined, stall_cycles increments by 1 in each COMPUTE cycle with act_valid=0, saturates at 16'hFFFF, and clears on start acceptance and on rst.
REQ-033 Without LEGO_SEQ_STALL_CNT_EN, stall_cycles SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-034 rst=1 for 2 cycles, then start, 16 back-to-back w_valid beats, act_valid=1 -> w_load_en on 16 consecutive cycles with w_row_sel 0..15; 32 compute_en; 31 drain cycles; done exactly once.
REQ-035 w_valid toggling 1,0,1,0 in LOAD -> only accepted beats produce w_load_en; w_row_sel contiguous 0..15; w_row_data equals the w_data from the previous cycle.
REQ-036 act_valid low for 5 cycles mid-COMPUTE with the macro defined -> still exactly 32 compute_en pulses; COMPUTE lengthened by 5 cycles; stall_cycles=5 at done.
REQ-037 start pulsed during LOAD, COMPUTE and DONE -> no state effect; exactly one done per accepted start.
REQ-038 rst asserted after row 7 is accepted -> next cycle IDLE, busy=0, no done; a following start reloads from w_row_sel=0.
REQ-039 Same stimulus as REQ-036 with the macro undefined -> stall_cycles=0 throughout.
